// File: rtl/led_frame_write_arbiter_pkg.sv
// Shared types for the LED frame write arbiter: frame geometry default,
// write request bundle, swap FSM states and the back-bank address helper.
package led_frame_write_arbiter_pkg;

  localparam int unsigned FRAME_WORDS_DEFAULT = 2048;
  localparam int unsigned ADDR_W_DEFAULT = 11;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } frame_wr_req_t;

  typedef enum logic {
    FILL,
    PENDING
  } swap_state_t;

  // Byte address of a word in the back bank; bank is the front index.
  function automatic logic [31:0] byte_addr(
    input logic        bank,
    input logic [31:0] addr,
    input logic [31:0] words
  );
    logic [31:0] base;
    base = bank ? 32'd0 : words;
    return (base + addr) << 2;
  endfunction

endpackage

// File: rtl/led_frame_write_arbiter_rr.sv
// Two-input round-robin grant with enable and pointer register.
// Ports: clk/reset, en gates all grants, valid per requester, grant one-hot.
module led_rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // ptr=0: req0 has priority, ptr=1: req1 has priority
  logic ptr;

  always_comb begin
    grant = '0;
    if (en) begin
      grant[0] = valid[0] & (~valid[1] | ~ptr);
      grant[1] = valid[1] & (~valid[0] | ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/led_frame_write_arbiter.sv
// Shares frame RAM port A between two writers and double-buffers the frame.
// Ports: req0/req1 valid-ready writers, swap/frame_done, RAM port A, status.
module led_frame_write_arbiter
  import led_frame_write_arbiter_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEFAULT,
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              req0_valid_in,
  output logic              req0_ready_out,
  input  logic [ADDR_W-1:0] req0_addr_in,
  input  logic [31:0]       req0_data_in,
  input  logic [3:0]        req0_strb_in,
  input  logic              req1_valid_in,
  output logic              req1_ready_out,
  input  logic [ADDR_W-1:0] req1_addr_in,
  input  logic [31:0]       req1_data_in,
  input  logic [3:0]        req1_strb_in,
  input  logic              swap_req_in,
  input  logic              frame_done_in,
  output logic              bank_out,
  output logic              swap_pending_out,
  output logic [3:0]        ram_wen_out,
  output logic [31:0]       ram_addr_out,
  output logic [31:0]       ram_data_out,
  output logic [15:0]       drop_count_out
);

  localparam logic [31:0] WORDS = 32'(FRAME_WORDS);

  swap_state_t   state;
  logic          en;
  logic [1:0]    grant;
  logic          hs;
  logic          in_range;
  frame_wr_req_t sel;
  logic [3:0]    wen_q;

  // Writers are held off while a swap is pending and in the cycle
  // the swap request lands, so no write can straddle a bank toggle.
  assign en = !reset_in && (state == FILL) && !swap_req_in;

  led_rr_arbiter2 u_arb (
    .clk   (clk_in),
    .reset (reset_in),
    .en    (en),
    .valid ({req1_valid_in, req0_valid_in}),
    .grant (grant)
  );

  assign req0_ready_out = grant[0];
  assign req1_ready_out = grant[1];

  always_comb begin
    sel.addr = 32'(req0_addr_in);
    sel.data = req0_data_in;
    sel.strb = req0_strb_in;
    if (grant[1]) begin
      sel.addr = 32'(req1_addr_in);
      sel.data = req1_data_in;
      sel.strb = req1_strb_in;
    end
  end

  assign hs       = |grant;
  assign in_range = sel.addr < WORDS;

  // A write registered just before reset must never reach the RAM.
  assign ram_wen_out      = reset_in ? 4'h0 : wen_q;
  assign swap_pending_out = (state == PENDING);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state          <= FILL;
      bank_out       <= 1'b0;
      wen_q          <= '0;
      ram_addr_out   <= '0;
      ram_data_out   <= '0;
      drop_count_out <= '0;
    end else begin
      wen_q <= '0;
      if (hs && in_range) begin
        wen_q        <= sel.strb;
        ram_addr_out <= byte_addr(bank_out, sel.addr, WORDS);
        ram_data_out <= sel.data;
      end
      if (hs && !in_range && drop_count_out != 16'hFFFF) begin
        drop_count_out <= drop_count_out + 16'd1;
      end
      unique case (state)
        FILL: begin
          if (swap_req_in) begin
            state <= PENDING;
          end
        end
        PENDING: begin
          if (frame_done_in) begin
            state    <= FILL;
            bank_out <= ~bank_out;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_write_arbiter.sv
// Scoreboard bench for led_frame_write_arbiter: directed cases, drop counter
// saturation and a randomized phase against a behavioural model.
module tb_led_frame_write_arbiter;

  localparam int FW = 2048;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          v0, v1, r0, r1;
  logic [AW-1:0] a0, a1;
  logic [31:0]   d0, d1;
  logic [3:0]    s0, s1;
  logic          swap, fd;
  logic          bank, pend;
  logic [3:0]    wen;
  logic [31:0]   waddr, wdata;
  logic [15:0]   drop;

  always #5 clk = ~clk;

  led_frame_write_arbiter #(.FRAME_WORDS(FW), .ADDR_W(AW)) dut (
    .clk_in           (clk),
    .reset_in         (rst),
    .req0_valid_in    (v0),
    .req0_ready_out   (r0),
    .req0_addr_in     (a0),
    .req0_data_in     (d0),
    .req0_strb_in     (s0),
    .req1_valid_in    (v1),
    .req1_ready_out   (r1),
    .req1_addr_in     (a1),
    .req1_data_in     (d1),
    .req1_strb_in     (s1),
    .swap_req_in      (swap),
    .frame_done_in    (fd),
    .bank_out         (bank),
    .swap_pending_out (pend),
    .ram_wen_out      (wen),
    .ram_addr_out     (waddr),
    .ram_data_out     (wdata),
    .drop_count_out   (drop)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];

  // Model: front bank, swap waiting, who was granted last, drop count.
  bit m_bank = 0;
  bit m_pend = 0;
  bit m_last = 1;
  int m_drop = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: checks status/ready, predicts the next state.
  always @(negedge clk) begin : model
    bit          e0, e1;
    int          ad;
    logic [31:0] dt;
    logic [3:0]  st;
    chk("bank", 32'(bank), 32'(m_bank));
    chk("pending", 32'(pend), 32'(m_pend));
    chk("drop", 32'(drop), 32'(m_drop));
    e0 = 0;
    e1 = 0;
    if (!rst && !m_pend && !swap) begin
      if (v0 && v1) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    chk("ready0", 32'(r0), 32'(e0));
    chk("ready1", 32'(r1), 32'(e1));
    if (rst) begin
      m_bank = 0;
      m_pend = 0;
      m_last = 1;
      m_drop = 0;
    end else begin
      if (e0 || e1) begin
        ad = e0 ? int'(a0) : int'(a1);
        dt = e0 ? d0 : d1;
        st = e0 ? s0 : s1;
        m_last = e1;
        if (ad < FW)
          q.push_back('{cyc + 1, st,
                        32'(((m_bank ? 0 : FW) + ad) * 4), dt});
        else if (m_drop < 65535)
          m_drop++;
      end
      if (!m_pend && swap) begin
        m_pend = 1;
      end else if (m_pend && fd) begin
        m_pend = 0;
        m_bank = !m_bank;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the RAM port is written.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      chk("wen_in_reset", 32'(wen), 32'd0);
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    end else if (wen != 4'h0) begin
      if (q.size() == 0 || q[0].due != cyc) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: wen %h addr %h, none expected (cycle %0d)",
                 wen, waddr, cyc);
      end else begin
        e = q.pop_front();
        chk("wen", 32'(wen), 32'(e.wen));
        chk("ram_addr", waddr, e.addr);
        chk("ram_data", wdata, e.data);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_write: wen 0, expected wen %h addr %h (cycle %0d)",
               e.wen, e.addr, cyc);
    end
  end

  task automatic idle();
    rst = 0; v0 = 0; v1 = 0; swap = 0; fd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_req(input bit which, input bit oor);
    logic [AW-1:0] ad;
    ad = oor ? AW'(FW + $urandom_range(0, 4095 - FW))
             : AW'($urandom_range(0, FW - 1));
    if (!which) begin
      v0 = 1; a0 = ad; d0 = $urandom; s0 = 4'($urandom_range(1, 15));
    end else begin
      v1 = 1; a1 = ad; d1 = $urandom; s1 = 4'($urandom_range(1, 15));
    end
  endtask

  initial begin
    idle();
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; s0 = '0; s1 = '0;
    rst = 1;
    repeat (3) tick();
    idle();
    chk("reset_addr", waddr, 32'd0);
    chk("reset_data", wdata, 32'd0);
    chk("reset_wen", 32'(wen), 32'd0);

    // single req0 write to back bank 1: byte address 0x2014
    v0 = 1; a0 = AW'(5); d0 = 32'hA5A5A5A5; s0 = 4'hF;
    tick();
    idle();
    chk("t1_addr_const", waddr, 32'h2014);
    tick();

    // both valid: alternating grants, four back-to-back writes
    rst = 1; tick(); idle();
    repeat (4) begin
      rnd_req(0, 0);
      rnd_req(1, 0);
      tick();
    end
    idle();
    tick();

    // swap, frame_done 20 cycles later, writers blocked meanwhile
    swap = 1; rnd_req(0, 0); tick();
    swap = 0;
    repeat (19) begin rnd_req(0, 0); tick(); end
    fd = 1; tick(); fd = 0;
    repeat (4) begin rnd_req(0, 0); rnd_req(1, 0); tick(); end
    idle();
    tick();

    // swap_req and frame_done together: pending, no toggle yet
    swap = 1; fd = 1; tick(); idle();
    repeat (5) begin rnd_req(1, 0); tick(); end
    fd = 1; tick(); idle();
    rnd_req(1, 0); tick(); idle();
    tick();

    // out-of-range drop, then saturate the counter
    v1 = 1; a1 = AW'(FW); d1 = $urandom; s1 = 4'hF;
    tick(); idle(); tick();
    repeat (65540) begin rnd_req(1, 1); tick(); end
    idle();
    tick();

    // randomized traffic with swaps, frame ends and rare resets
    repeat (3000) begin
      idle();
      if ($urandom_range(0, 3) != 0) rnd_req(0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) != 0) rnd_req(1, $urandom_range(0, 9) == 0);
      swap = ($urandom_range(0, 29) == 0);
      fd   = ($urandom_range(0, 19) == 0);
      rst  = ($urandom_range(0, 499) == 0);
      tick();
    end
    idle();
    tick();

    // reset the cycle after a handshake: that write never appears
    rnd_req(0, 0); tick();
    idle(); rst = 1; tick();
    idle();
    repeat (3) tick();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
